// File: rtl/rca_pkg.sv
// Shared types and helpers for the sequential ripple-carry adder/subtractor.
//   state_e      : controller states (IDLE, CALC, DONE)
//   calc_nchunk  : number of compute cycles for a given width/chunk size
//   sat_max/min  : signed saturation limits for a given width (width <= 64)
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic int unsigned calc_nchunk(int unsigned width, int unsigned chunk);
    return width / chunk;
  endfunction

  // 0 followed by all ones, right-aligned in 64 bits.
  function automatic logic [63:0] sat_max(int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // 1 followed by all zeros, right-aligned in 64 bits.
  function automatic logic [63:0] sat_min(int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
//   a, b  : addend slices
//   cin   : carry into the LSB
//   s     : sum slice
//   c_msb : carry into the slice MSB (needed for signed overflow)
//   cout  : carry out of the slice MSB
module rca_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             c_msb,
  output logic             cout
);

  always_comb begin : ripple
    logic c;
    c     = cin;
    c_msb = cin;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      c_msb = c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_addsub_seq.sv
// Multi-cycle ripple-carry adder/subtractor, CHUNK bits per clock, LSB first.
// Optional feature: define RCA_SAT_EN to saturate sum to the signed limits on overflow.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : operand handshake (a, b, sub)
//   a, b, sub            : operands; sub=1 computes a - b
//   out_valid, out_ready : result handshake
//   sum, c_out, ovf      : result, carry out of MSB (1 = no borrow on sub), signed overflow
module rca_addsub_seq
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("rca_addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;     // already inverted for subtract
  logic            carry_q;
  logic [IDXW-1:0] idx_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_msb;
  logic             c_chunk;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_final;

  always_comb begin
    a_chunk  = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk  = b_q[idx_q*CHUNK +: CHUNK];
    sum_next = sum;
    sum_next[idx_q*CHUNK +: CHUNK] = s_chunk;
  end

  rca_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .s    (s_chunk),
    .c_msb(c_msb),
    .cout (c_chunk)
  );

`ifdef RCA_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  // Overflow only happens when both addends share a sign, so A's sign is the true sign.
  always_comb begin
    if (c_msb ^ c_chunk) begin
      sum_final = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_final = sum_next;
    end
  end
`else
  assign sum_final = sum_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b ^ {WIDTH{sub}};
            carry_q  <= sub;
            idx_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          carry_q <= c_chunk;
          if (idx_q == LAST_IDX) begin
            sum       <= sum_final;
            c_out     <= c_chunk;
            ovf       <= c_msb ^ c_chunk;
            idx_q     <= '0;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            sum   <= sum_next;
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_addsub_seq.sv
module tb_rca_addsub_seq;

`ifdef RCA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit, 4-bit chunks
  logic       in_valid8 = 1'b0, in_ready8, sub8 = 1'b0, out_valid8, out_ready8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       c_out8, ovf8;
  // 4-bit, 1-bit chunks
  logic       in_valid4 = 1'b0, in_ready4, sub4 = 1'b0, out_valid4, out_ready4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       c_out4, ovf4;

  rca_addsub_seq #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .c_out(c_out8),
    .ovf(ovf8)
  );

  rca_addsub_seq #(.WIDTH(4), .CHUNK(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .c_out(c_out4),
    .ovf(ovf4)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on plain integers.
  task automatic model(input int w, input longint a, input longint b, input bit s,
                       output longint es, output bit ec, output bit ev);
    longint m, half, sa, sb, tr, ur;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    tr   = s ? sa - sb : sa + sb;
    ev   = (tr >= half) || (tr < -half);
    ur   = s ? a - b : a + b;
    ec   = s ? (a >= b) : (ur >= m);
    es   = ur & (m - 1);
    if (SAT && ev) es = (tr > 0) ? half - 1 : half;
  endtask

  // Called at #1 after an edge with the 8-bit DUT idle and out_ready8 = 1.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s,
                      input logic [7:0] es, input bit ec, input bit ev, input string nm);
    int n;
    in_valid8 = 1'b1; a8 = a; b8 = b; sub8 = s;
    n = 0;
    while (!in_ready8 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk({nm, " ready timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid8 && n < 20);
    chk({nm, " latency"}, n, 2);
    chk({nm, " sum"}, sum8, es);
    chk({nm, " c_out"}, c_out8, ec);
    chk({nm, " ovf"}, ovf8, ev);
    @(posedge clk); #1;
    chk({nm, " out_valid drop"}, out_valid8, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         s;
    logic [7:0] es;
    bit         ec;
    bit         ev;
    string      nm;
  } vec_t;

  initial begin
    vec_t vecs[8];
    longint es;
    bit ec, ev;
    logic [7:0] ra, rb;
    bit rs;
    int n, cyc, sent, got;
    bit accepted;
    longint exp_s[$];
    bit exp_c[$], exp_v[$];

    vecs[0] = '{8'h06, 8'h0C, 1'b0, 8'h12, 1'b0, 1'b0, "add_06_0c"};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, "add_7f_01"};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01"};
    vecs[3] = '{8'h07, 8'h0E, 1'b1, 8'hF9, 1'b0, 1'b0, "sub_07_0e"};
    vecs[4] = '{8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, "sub_80_01"};
    vecs[5] = '{8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1, "add_80_80"};
    vecs[6] = '{8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, "sub_55_55"};
    vecs[7] = '{8'h7F, 8'hFF, 1'b1, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, "sub_7f_ff"};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst in_ready8", in_ready8, 1);
    chk("rst out_valid8", out_valid8, 0);
    chk("rst sum8", sum8, 0);
    chk("rst c_out8", c_out8, 0);
    chk("rst ovf8", ovf8, 0);
    chk("rst in_ready4", in_ready4, 1);
    chk("rst out_valid4", out_valid4, 0);

    foreach (vecs[i]) run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].es, vecs[i].ec,
                           vecs[i].ev, vecs[i].nm);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      model(8, longint'(ra), longint'(rb), rs, es, ec, ev);
      run8(ra, rb, rs, 8'(es), ec, ev, "rand8");
    end

    // Backpressure: result held, new requests ignored.
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; a8 = 8'h06; b8 = 8'h0C; sub8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid8 && n < 20);
    chk("bp latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", out_valid8, 1);
      chk("bp sum", sum8, 8'h12);
      chk("bp c_out", c_out8, 0);
      chk("bp in_ready", in_ready8, 0);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      @(posedge clk); #1;
    end
    out_ready8 = 1'b1; in_valid8 = 1'b0;
    @(posedge clk); #1;
    chk("bp release out_valid", out_valid8, 0);
    chk("bp release in_ready", in_ready8, 1);
    run8(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, "after_bp");

    // Reset mid-CALC discards the operation.
    in_valid8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst in_ready", in_ready8, 1);
    chk("midrst out_valid", out_valid8, 0);
    chk("midrst sum", sum8, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst no result", out_valid8, 0);
    end
    run8(8'h02, 8'h09, 1'b1, 8'hF9, 1'b0, 1'b0, "sub_02_09");

    // 4-bit, 1-bit-chunk directed case.
    in_valid4 = 1'b1; a4 = 4'hE; b4 = 4'h8; sub4 = 1'b0;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid4 && n < 20);
    chk("w4 latency", n, 4);
    chk("w4 sum", sum4, SAT ? 4'h8 : 4'h6);
    chk("w4 c_out", c_out4, 1);
    chk("w4 ovf", ovf4, 1);
    @(posedge clk); #1;

    // Streamed random ops with random backpressure on the 4-bit DUT.
    sent = 0; got = 0; cyc = 0; accepted = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      if (accepted) begin
        in_valid4 = 1'b0;
        accepted = 1'b0;
      end
      out_ready4 = ($urandom_range(3) != 0);
      if (out_valid4 && out_ready4) begin
        if (exp_s.size() == 0) begin
          chk("w4 rand unexpected result", 1, 0);
        end else begin
          chk("w4 rand sum", sum4, exp_s.pop_front());
          chk("w4 rand c_out", c_out4, exp_c.pop_front());
          chk("w4 rand ovf", ovf4, exp_v.pop_front());
        end
        got++;
      end
      if (!in_valid4 && sent < 1000) begin
        a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
        in_valid4 = 1'b1;
      end
      if (in_valid4 && in_ready4) begin
        model(4, longint'(a4), longint'(b4), sub4, es, ec, ev);
        exp_s.push_back(es); exp_c.push_back(ec); exp_v.push_back(ev);
        sent++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid4 = 1'b0;
    chk("w4 rand completed", got, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
